// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with one-shot and auto-reload modes
// and a registered interrupt line.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
  logic             pend_q, pend_d, irq_q, irq_d;
  logic             ctrl_wr, unused_addr;
  assign ctrl_wr     = we && addr[3:2] == 2'd0;
  assign unused_addr = ^{addr[31:4], addr[1:0]};
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    count_d  = count_q;
    pend_d   = ctrl_wr ? 1'b0 : pend_q;
    preset_d = (we && addr[3:2] == 2'd1) ? wdata[CNT_W-1:0] : preset_q;
    unique case (state_q)
      IDLE: state_d = ctrl_q[0] ? LOAD : IDLE;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) state_d = IDLE;
        else if (count_q > CNT_W'(1)) count_d = count_q - CNT_W'(1);
        else begin
          count_d = '0;
          state_d = INT;
          pend_d  = 1'b1;
        end
      end
      INT: begin
        if (ctrl_q[2:1] == 2'd1) begin
          state_d = LOAD;
          pend_d  = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
    endcase
    // a CPU write overrides the hardware EN clear of a one-shot expiry
    if (ctrl_wr) ctrl_d = wdata[3:0];
    irq_d = ctrl_d[3] & pend_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end
  always_comb rdata = addr[3:2] == 2'd0 ? {28'd0, ctrl_q} :
                      addr[3:2] == 2'd1 ? 32'(preset_q) :
                      addr[3:2] == 2'd2 ? 32'(count_q) : 32'd0;
  assign irq = irq_q;
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: table-driven directed checks of timer_dev plus hand-written
// sequences for latency, simultaneous events, mid-run changes and async reset.
module tb_timer_dev;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;
  vec_t vecs[$];

  timer_dev #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic add(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [31:0] ra, input logic [31:0] er, input logic ei);
    vecs.push_back('{w, wa, wd, ra, er, ei});
  endtask

  task automatic step(input logic w, input logic [31:0] wa, input logic [31:0] wd);
    we = w;
    addr = wa;
    wdata = wd;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] ra,
                     input logic [31:0] er, input logic ei);
    addr = ra;
    #1;
    checks++;
    if (rdata !== er || irq !== ei) begin
      errors++;
      $display("FAIL %s: rdata=%h irq=%b expected rdata=%h irq=%b", name, rdata, irq, er, ei);
    end
  endtask

  task automatic latency(input string name, input int p, input int exp_n);
    int n = 0;
    step(1, 32'h4, p);
    step(1, 32'h0, 32'h9);
    while (irq !== 1'b1 && n < 20) begin
      step(0, 0, 0);
      n++;
    end
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL %s: edges=%0d expected %0d", name, n, exp_n);
    end
    step(1, 32'h0, 32'h0);
    step(0, 0, 0);
  endtask

  initial begin
    logic [31:0] v0;
    // reset state
    add(0, 0, 0, 32'h0, 0, 0);
    add(0, 0, 0, 32'h4, 0, 0);
    add(0, 0, 0, 32'h8, 0, 0);
    add(0, 0, 0, 32'hC, 0, 0);
    // one-shot, PRESET=5, CTRL=EN|IM
    add(1, 32'h4, 5, 32'h4, 5, 0);
    add(1, 32'h0, 32'h9, 32'h0, 32'h9, 0);
    add(0, 0, 0, 32'h8, 0, 0);
    add(0, 0, 0, 32'h8, 5, 0);
    add(0, 0, 0, 32'h8, 4, 0);
    add(0, 0, 0, 32'h8, 3, 0);
    add(0, 0, 0, 32'h8, 2, 0);
    add(0, 0, 0, 32'h8, 1, 0);
    add(0, 0, 0, 32'h8, 0, 1);
    add(0, 0, 0, 32'h0, 32'h8, 1);
    add(0, 0, 0, 32'h8, 0, 1);
    // acknowledge
    add(1, 32'h0, 32'h0, 32'h8, 0, 0);
    add(0, 0, 0, 32'h0, 0, 0);
    // auto-reload, PRESET=3, CTRL=EN|MODE1|IM
    add(1, 32'h4, 3, 32'h4, 3, 0);
    add(1, 32'h0, 32'hB, 32'h0, 32'hB, 0);
    add(0, 0, 0, 32'h8, 0, 0);
    add(0, 0, 0, 32'h8, 3, 0);
    add(0, 0, 0, 32'h8, 2, 0);
    add(0, 0, 0, 32'h8, 1, 0);
    add(0, 0, 0, 32'h8, 0, 1);
    add(0, 0, 0, 32'h8, 0, 0);
    add(0, 0, 0, 32'h8, 3, 0);
    add(0, 0, 0, 32'h8, 2, 0);
    add(0, 0, 0, 32'h8, 1, 0);
    add(0, 0, 0, 32'h8, 0, 1);
    add(0, 0, 0, 32'h8, 0, 0);
    // auto-reload with IM=0: count still cycles, irq stays low
    add(1, 32'h0, 32'h3, 32'h8, 3, 0);
    add(0, 0, 0, 32'h8, 2, 0);
    add(0, 0, 0, 32'h8, 1, 0);
    add(0, 0, 0, 32'h8, 0, 0);
    add(0, 0, 0, 32'h8, 0, 0);
    add(0, 0, 0, 32'h8, 3, 0);
    // stop, then COUNT and addr 0xC writes are ignored
    add(1, 32'h0, 32'h0, 32'h8, 2, 0);
    add(0, 0, 0, 32'h8, 2, 0);
    add(1, 32'h8, 32'h55, 32'h8, 2, 0);
    add(1, 32'hC, 32'hFF, 32'hC, 0, 0);
    add(0, 0, 0, 32'h0, 0, 0);

    #3 reset = 1'b0;
    #20 reset = 1'b1;
    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].waddr, vecs[i].wdata);
      chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp_rdata, vecs[i].exp_irq);
    end

    // mid-run PRESET write and EN clear
    step(1, 32'h4, 10);
    step(1, 32'h0, 32'h1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("mid_start", 32'h8, 10, 0);
    step(1, 32'h4, 2);
    chk("mid_preset_ignored", 32'h8, 9, 0);
    chk("mid_preset_stored", 32'h4, 2, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("mid_seven", 32'h8, 7, 0);
    step(1, 32'h0, 32'h0);
    addr = 32'h8;
    #1 v0 = rdata;
    checks++;
    if (v0 != 6 && v0 != 7) begin
      errors++;
      $display("FAIL freeze_val: count=%0d expected 6 or 7", v0);
    end
    repeat (5) step(0, 0, 0);
    chk("freeze_hold", 32'h8, v0, 0);

    // latency boundaries
    latency("lat_p0", 0, 3);
    latency("lat_p1", 1, 3);
    latency("lat_p4", 4, 6);

    // simultaneous events
    step(1, 32'h4, 1);
    step(1, 32'h0, 32'h9);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 32'h0, 32'h9);
    chk("set_wins", 32'h0, 32'h9, 1);
    step(1, 32'h0, 32'h9);
    chk("cpu_wins", 32'h0, 32'h9, 0);
    step(1, 32'h0, 32'h0);
    repeat (3) step(0, 0, 0);

    // async reset mid-count
    step(1, 32'h4, 6);
    step(1, 32'h0, 32'h9);
    repeat (4) step(0, 0, 0);
    chk("pre_reset", 32'h8, 4, 0);
    reset = 1'b0;
    chk("rst_count", 32'h8, 0, 0);
    chk("rst_ctrl", 32'h0, 0, 0);
    chk("rst_preset", 32'h4, 0, 0);
    reset = 1'b1;
    repeat (5) step(0, 0, 0);
    chk("post_rst_count", 32'h8, 0, 0);
    chk("post_rst_ctrl", 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
